// File: rtl/iob_cache_write_buffer_pkg.sv
// rtl/iob_cache_write_buffer_pkg.sv - shared defaults, drain state encoding and entry sizing
//
// Purpose: common definitions for the write-through buffer and its register file.
// Ports:   none (package).

package iob_cache_write_buffer_pkg;

   localparam int DEF_FE_ADDR_W = 24;
   localparam int DEF_FE_DATA_W = 32;
   localparam int DEF_DEPTH_W   = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } drain_state_e;

   // Stored entry is {word address, data, strobes}.
   function automatic int entry_w(input int fe_addr_w, input int fe_data_w);
      return (fe_addr_w - $clog2(fe_data_w / 8)) + fe_data_w + (fe_data_w / 8);
   endfunction

endpackage

// File: rtl/iob_cache_write_buffer_mem.sv
// rtl/iob_cache_write_buffer_mem.sv - entry register file with head read and address compare
//
// Purpose: DEPTH x ENTRY_W storage, one write port, asynchronous read of one slot,
//          and a per-slot word-address match vector used for read-after-write hazards.
// Ports:   clk_i         clock
//          wr_en_i       write enable, stores wr_entry_i at wr_ptr_i
//          rd_ptr_i      slot to read combinationally onto rd_entry_o
//          lookup_addr_i word address compared against every slot
//          match_o       bit i set when slot i holds lookup_addr_i (occupancy not applied)

module iob_cache_write_buffer_mem #(
   parameter int WA_W    = 22,
   parameter int ENTRY_W = 58,
   parameter int DEPTH_W = 2
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [DEPTH_W-1:0]    wr_ptr_i,
   input  logic [ENTRY_W-1:0]    wr_entry_i,
   input  logic [DEPTH_W-1:0]    rd_ptr_i,
   output logic [ENTRY_W-1:0]    rd_entry_o,
   input  logic [WA_W-1:0]       lookup_addr_i,
   output logic [2**DEPTH_W-1:0] match_o
);

   localparam int DEPTH = 2 ** DEPTH_W;

   // Contents are only meaningful for occupied slots, so no reset is needed.
   logic [ENTRY_W-1:0] rf_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         rf_q[wr_ptr_i] <= wr_entry_i;
      end
   end

   assign rd_entry_o = rf_q[rd_ptr_i];

   always_comb begin
      match_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_o[i] = (rf_q[i][ENTRY_W-1 -: WA_W] == lookup_addr_i);
      end
   end

endmodule

// File: rtl/iob_cache_write_buffer.sv
// rtl/iob_cache_write_buffer.sv - write-through FIFO feeding the cache back-end write channel
//
// Purpose: buffers front-end word writes and drains them in order over a valid/ready
//          link; flags read-after-write hazards against every occupied entry.
// Ports:   clk_i, arst_n_i                      clock, async active-low reset
//          push_valid_i/addr/wdata/wstrb        front-end write request
//          push_ready_o                         buffer not full
//          write_valid_o/addr/wdata/wstrb       head entry presented to back-end
//          write_ready_i                        back-end accepts presented entry
//          lookup_addr_i, lookup_hit_o          hazard check against occupied entries
//          empty_o, full_o, level_o             occupancy status

module iob_cache_write_buffer
   import iob_cache_write_buffer_pkg::*;
#(
   parameter int FE_ADDR_W   = DEF_FE_ADDR_W,
   parameter int FE_DATA_W   = DEF_FE_DATA_W,
   parameter int FE_NBYTES   = FE_DATA_W / 8,
   parameter int FE_NBYTES_W = $clog2(FE_NBYTES),
   parameter int DEPTH_W     = DEF_DEPTH_W
) (
   input  logic                            clk_i,
   input  logic                            arst_n_i,
   input  logic                            push_valid_i,
   input  logic [FE_ADDR_W-FE_NBYTES_W-1:0] push_addr_i,
   input  logic [FE_DATA_W-1:0]            push_wdata_i,
   input  logic [FE_NBYTES-1:0]            push_wstrb_i,
   output logic                            push_ready_o,
   output logic                            write_valid_o,
   output logic [FE_ADDR_W-FE_NBYTES_W-1:0] write_addr_o,
   output logic [FE_DATA_W-1:0]            write_wdata_o,
   output logic [FE_NBYTES-1:0]            write_wstrb_o,
   input  logic                            write_ready_i,
   input  logic [FE_ADDR_W-FE_NBYTES_W-1:0] lookup_addr_i,
   output logic                            lookup_hit_o,
   output logic                            empty_o,
   output logic                            full_o,
   output logic [DEPTH_W:0]                level_o
);

   localparam int WA_W    = FE_ADDR_W - FE_NBYTES_W;
   localparam int DEPTH   = 2 ** DEPTH_W;
   localparam int ENTRY_W = entry_w(FE_ADDR_W, FE_DATA_W);
   localparam logic [DEPTH_W:0] CNT_ZERO = '0;
   localparam logic [DEPTH_W:0] CNT_ONE  = (DEPTH_W+1)'(1);
   localparam logic [DEPTH_W:0] CNT_FULL = (DEPTH_W+1)'(DEPTH);

   logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_W:0]   count_q, count_d;
   drain_state_e       state_q, state_d;
   logic [ENTRY_W-1:0] out_q, out_d;

   logic               push, pop;
   logic [DEPTH_W-1:0] rd_addr;
   logic [DEPTH_W-1:0] slot_off;
   logic [ENTRY_W-1:0] push_entry, rd_entry;
   logic [DEPTH-1:0]   match, occupied;

   assign full_o        = (count_q == CNT_FULL);
   assign empty_o       = (count_q == CNT_ZERO);
   assign level_o       = count_q;
   assign push_ready_o  = !full_o;
   assign write_valid_o = (state_q == ST_ISSUE);

   // Ready is taken from the registered count only, so a pop never frees room for
   // a push in the same cycle.
   assign push = push_valid_i && push_ready_o;
   assign pop  = write_valid_o && write_ready_i;

   assign push_entry = {push_addr_i, push_wdata_i, push_wstrb_i};

   // While issuing, the output register already holds the head, so the read port
   // looks one ahead to reload it without a bubble after a pop.
   assign rd_addr = (state_q == ST_ISSUE) ? rd_ptr_q + 1'b1 : rd_ptr_q;

   iob_cache_write_buffer_mem #(
      .WA_W    (WA_W),
      .ENTRY_W (ENTRY_W),
      .DEPTH_W (DEPTH_W)
   ) u_mem (
      .clk_i         (clk_i),
      .wr_en_i       (push),
      .wr_ptr_i      (wr_ptr_q),
      .wr_entry_i    (push_entry),
      .rd_ptr_i      (rd_addr),
      .rd_entry_o    (rd_entry),
      .lookup_addr_i (lookup_addr_i),
      .match_o       (match)
   );

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      case (state_q)
         ST_IDLE: begin
            if (count_q != CNT_ZERO) begin
               state_d = ST_ISSUE;
               out_d   = rd_entry;
            end
         end
         ST_ISSUE: begin
            if (pop) begin
               if (count_d != CNT_ZERO) begin
                  // With a single occupant the successor is the word arriving now,
                  // which is not yet in the register file.
                  out_d = (count_q == CNT_ONE) ? push_entry : rd_entry;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_IDLE;
         out_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         out_q    <= out_d;
      end
   end

   // A slot is occupied when its distance from the head is below the count; the
   // presented head stays occupied until its acceptance edge.
   always_comb begin
      occupied = '0;
      slot_off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_off    = DEPTH_W'(i) - rd_ptr_q;
         occupied[i] = ({1'b0, slot_off} < count_q);
      end
   end

   assign lookup_hit_o = |(match & occupied);

   assign {write_addr_o, write_wdata_o, write_wstrb_o} = out_q;

endmodule
